// File: rtl/csa_word_sequencer.sv
// csa_word_sequencer: adds two WIDTH-bit operands using one shared 4-bit carry-select slice.
// The slice handles one nibble per clock, least significant nibble first, and its
// carry-out is registered and fed back as the carry-in of the next nibble.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands present           in_ready   block can accept operands (IDLE)
//   a, b       WIDTH-bit operands         cin        carry-in to nibble 0
//   out_valid  result valid, held         out_ready  consumer accepts result
//   sum        a+b+cin, low WIDTH bits    cout       carry out of the MSB nibble
//   ovf        two's-complement overflow  busy       high while in RUN or DONE
//
// carry_select: 4-bit slice. Both candidate sums (carry-in 0 and 1) are formed up
// front and the incoming carry only drives the final select.
//   x, y   4-bit addends    carry  carry-in
//   s      4-bit sum        cout   carry-out

module carry_select (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       carry,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] sum0;
    logic [4:0] sum1;

    always_comb begin
        sum0 = {1'b0, x} + {1'b0, y};
        sum1 = sum0 + 5'd1;
        {cout, s} = carry ? sum1 : sum0;
    end

endmodule

module csa_word_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NSLICE - 1);

    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("csa_word_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [3:0] slice_x;
    logic [3:0] slice_y;
    logic [3:0] slice_s;
    logic       slice_cout;

    assign slice_x = a_q[4*idx_q +: 4];
    assign slice_y = b_q[4*idx_q +: 4];

    carry_select u_slice (
        .x     (slice_x),
        .y     (slice_y),
        .carry (carry_q),
        .s     (slice_s),
        .cout  (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StRun;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            StRun: begin
                sum_d[4*idx_q +: 4] = slice_s;
                carry_d             = slice_cout;
                if (idx_q == LastIdx) begin
                    // Index parks at 0 so it never points past the operand in DONE.
                    idx_d       = '0;
                    state_d     = StDone;
                    cout_d      = slice_cout;
                    // Same-sign operands producing an opposite-sign result.
                    ovf_d       = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (slice_s[3] ^ a_q[WIDTH-1]);
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_word_sequencer.sv
// Scoreboard bench for csa_word_sequencer: a 16-bit instance and a 4-bit instance.
// Stimulus pushes hand-computed results; per-instance monitors pop and compare
// when out_valid rises, including the accept-to-valid latency.

module tb_csa_word_sequencer;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16;
    logic [15:0] a16, b16, sum16;
    logic        cout16, ovf16, busy16;

    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4;
    logic [3:0]  a4, b4, sum4;
    logic        cout4, ovf4, busy4;

    logic        ov16_prev, ov4_prev;
    exp_t        q16[$];
    exp_t        q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csa_word_sequencer #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .sum       (sum16),
        .cout      (cout16),
        .ovf       (ovf16),
        .busy      (busy16)
    );

    csa_word_sequencer #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4),
        .busy      (busy4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: compare on the rising edge of out_valid.
    always @(negedge clk) begin
        if (rst) begin
            ov16_prev <= 1'b0;
        end else begin
            if (out_valid16 && !ov16_prev) begin
                if (q16.size() == 0) begin
                    check("unexpected_result16", 32'(out_valid16), 32'd0);
                end else begin
                    check("sum16", 32'(sum16), 32'(q16[0].sum));
                    check("cout16", 32'(cout16), 32'(q16[0].cout));
                    check("ovf16", 32'(ovf16), 32'(q16[0].ovf));
                    check("latency16", 32'(cyc - q16[0].acc), 32'd4);
                    void'(q16.pop_front());
                end
            end
            ov16_prev <= out_valid16;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            ov4_prev <= 1'b0;
        end else begin
            if (out_valid4 && !ov4_prev) begin
                if (q4.size() == 0) begin
                    check("unexpected_result4", 32'(out_valid4), 32'd0);
                end else begin
                    check("sum4", {28'd0, sum4}, 32'(q4[0].sum));
                    check("cout4", 32'(cout4), 32'(q4[0].cout));
                    check("ovf4", 32'(ovf4), 32'(q4[0].ovf));
                    check("latency4", 32'(cyc - q4[0].acc), 32'd1);
                    void'(q4.pop_front());
                end
            end
            ov4_prev <= out_valid4;
        end
    end

    task automatic send(input bit d4, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic [15:0] es, input logic ec, input logic eo);
        int   n;
        exp_t e;
        @(negedge clk);
        if (d4) begin
            in_valid4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; cin4 = ci;
        end else begin
            in_valid16 = 1'b1; a16 = av; b16 = bv; cin16 = ci;
        end
        n = 0;
        while (((d4 && !in_ready4) || (!d4 && !in_ready16)) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_at_accept", 32'(d4 ? in_ready4 : in_ready16), 32'd1);
        e.sum = es; e.cout = ec; e.ovf = eo; e.acc = cyc + 1;
        if (d4) q4.push_back(e);
        else q16.push_back(e);
        @(negedge clk);
        if (d4) in_valid4 = 1'b0;
        else in_valid16 = 1'b0;
    endtask

    task automatic wait_done(input bit d4);
        int n;
        n = 0;
        while (((d4 ? q4.size() : q16.size()) != 0 || !(d4 ? in_ready4 : in_ready16))
               && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("result_handoff",
              32'(((d4 ? q4.size() : q16.size()) == 0) && (d4 ? in_ready4 : in_ready16)), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b1; out_ready16 = 1'b1;
        in_valid4 = 1'b1;  a4 = 4'h3;      b4 = 4'h4;      cin4 = 1'b1;  out_ready4 = 1'b1;

        // Reset held for two cycles with in_valid asserted.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid16), 32'd0);
            check("rst_sum", 32'(sum16), 32'd0);
            check("rst_cout", 32'(cout16), 32'd0);
            check("rst_ovf", 32'(ovf16), 32'd0);
            check("rst_busy", 32'(busy16), 32'd0);
            check("rst_busy4", 32'(busy4), 32'd0);
        end
        rst = 1'b0; in_valid16 = 1'b0; in_valid4 = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready16), 32'd1);
        check("in_ready4_after_rst", 32'(in_ready4), 32'd1);

        send(1'b0, 16'h0001, 16'h0006, 1'b0, 16'h0007, 1'b0, 1'b0); wait_done(1'b0);
        send(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0); wait_done(1'b0);
        send(1'b0, 16'hD00D, 16'hA00A, 1'b1, 16'h7018, 1'b1, 1'b1); wait_done(1'b0);
        send(1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1); wait_done(1'b0);

        // Backpressure: result held in DONE, a pulsed in_valid is ignored.
        out_ready16 = 1'b0;
        send(1'b0, 16'h1234, 16'h0101, 1'b0, 16'h1335, 1'b0, 1'b0);
        n = 0;
        while (!out_valid16 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_seen", 32'(out_valid16), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid16), 32'd1);
            check("bp_sum", 32'(sum16), 32'h1335);
            check("bp_cout", 32'(cout16), 32'd0);
            check("bp_in_ready", 32'(in_ready16), 32'd0);
            if (i == 2) begin
                in_valid16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
            end
            if (i == 3) in_valid16 = 1'b0;
        end
        out_ready16 = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", 32'(out_valid16), 32'd0);
        check("bp_release_in_ready", 32'(in_ready16), 32'd1);
        check("bp_sum_held_after_handoff", 32'(sum16), 32'h1335);
        send(1'b0, 16'h0005, 16'h0002, 1'b1, 16'h0008, 1'b0, 1'b0); wait_done(1'b0);

        // Reset after two nibbles of a transaction.
        @(negedge clk);
        in_valid16 = 1'b1; a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0;
        @(negedge clk);
        in_valid16 = 1'b0;
        check("midrun_busy", 32'(busy16), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("midrun_partial_sum", 32'(sum16), 32'h0055);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_rst_busy", 32'(busy16), 32'd0);
        check("midrun_rst_out_valid", 32'(out_valid16), 32'd0);
        check("midrun_rst_sum", 32'(sum16), 32'd0);
        check("midrun_rst_in_ready", 32'(in_ready16), 32'd1);
        send(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0); wait_done(1'b0);

        // 4-bit instance: single slice operation per add.
        send(1'b1, 16'h000D, 16'h000A, 1'b1, 16'h0008, 1'b1, 1'b0); wait_done(1'b1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/csa_word_sequencer.md
Name: csa_word_sequencer

Overview:
- Multi-cycle controller that adds two WIDTH-bit operands by sequencing a single 4-bit `carry_select` slice (ports x, y, carry, s, cout), one nibble per clock, LSB nibble first.
- The slice carry-out is registered and fed back as the next slice's carry-in.
- Upstream side uses a valid/ready handshake; downstream side uses a valid/ready handshake with a held result.
- Used wherever wide additions must share one small adder instead of instantiating WIDTH/4 slices.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise).
- NSLICE, WIDTH/4, derived local: number of 4-bit slice operations per add.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to nibble 0
- out_valid  output  1  result valid, held until taken
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a+b+cin, low WIDTH bits
- cout  output  1  carry out of MSB nibble
- ovf  output  1  two's-complement overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- States:
  - IDLE: in_ready=1.
  - RUN: nibbles in progress.
  - DONE: out_valid=1.
- Reset values: state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, busy=0, slice index=0, carry register=0. in_ready is 1 from the first cycle after reset. rst has priority over every other event.
- in_ready = (state==IDLE); combinational from state only.
- IDLE -> RUN on the edge where in_valid & in_ready:
  - a, b captured into internal registers.
  - carry register <= cin, index <= 0, sum <= 0.
  - Operand inputs are ignored at all other times.
- RUN, each edge:
  - Slice inputs: x=a_reg[4*idx+:4], y=b_reg[4*idx+:4], carry=carry register.
  - sum[4*idx+:4] <= s; carry register <= slice cout; idx <= idx+1.
- RUN -> DONE on the edge that processes idx==NSLICE-1. On that edge:
  - cout <= slice cout.
  - ovf <= a_reg[MSB] ~^ b_reg[MSB] & (s[3] ^ a_reg[MSB]), i.e. same-sign operands giving an opposite-sign result.
  - out_valid <= 1.
- Latency: out_valid rises exactly NSLICE clocks after the accept edge (16-bit: 4; WIDTH=4: 1).
- DONE: sum, cout, ovf and out_valid are held stable while out_ready=0; in_valid is ignored.
- DONE -> IDLE on the edge where out_valid & out_ready. On that edge out_valid <= 0; sum/cout/ovf keep their values until the next accept.
- No overlap: a new accept is possible at the earliest one cycle after result handoff. Back-to-back throughput is one add per NSLICE+2 cycles.
- out_ready high in IDLE or RUN has no effect.
- Reset mid-RUN or mid-DONE: the transaction is discarded, and all state and outputs return to their reset values on that edge.
- busy = (state!=IDLE).

Test Plan (WIDTH=16 unless stated):
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, sum=0x0000, cout=0, ovf=0, busy=0 throughout; in_ready=1 on the first cycle after rst falls.
- Simple add: a=0x0001, b=0x0006, cin=0 -> out_valid rises 4 clocks after accept; sum=0x0007, cout=0, ovf=0.
- Full carry ripple through all nibbles: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0xD00D, b=0xA00A, cin=1 -> sum=0x7018, cout=1, ovf=1.
- Signed overflow via cin: a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout stable; in_ready=0; a pulsed in_valid is not accepted.
  - Raise out_ready -> IDLE on the next edge.
  - Next accept (a=0x0005, b=0x0002, cin=1) -> sum=0x0008.
- Reset mid-RUN and WIDTH=4:
  - Assert rst after 2 nibbles -> IDLE and zeroed outputs on the next edge; a following add completes correctly.
  - Separate WIDTH=4 build: a=0xD, b=0xA, cin=1 -> out_valid 1 clock after accept, sum=0x8, cout=1, ovf=0.
